// File: rtl/ram_1port_arb_if.sv
// ============================================================================
//  Module      : ram_1port_arb_if
//  Description : Bundle of the two client request ports, their read-response
//                paths and the single-port RAM bus served by ram_1port_arb.
//                slave  = arbiter side, master = client/RAM side.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface ram_1port_arb_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    // Client port A / B requests
    logic              req_a;
    logic              req_b;
    logic              we_a;
    logic              we_b;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_a;
    logic [DATA_W-1:0] wdata_b;

    // Grants and read responses
    logic              gnt_a;
    logic              gnt_b;
    logic              rvalid_a;
    logic              rvalid_b;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;

    // RAM side
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic              ram_rden;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
        input  ram_q,
        output gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b,
        output ram_addr, ram_data, ram_wren, ram_rden
    );

    modport master (
        output req_a, req_b, we_a, we_b, addr_a, addr_b, wdata_a, wdata_b,
        output ram_q,
        input  gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b,
        input  ram_addr, ram_data, ram_wren, ram_rden
    );
endinterface

`default_nettype wire

// File: rtl/ram_1port_arb.sv
// ============================================================================
//  Module      : ram_1port_arb
//  Description : Two-requester arbiter for a single-port RAM. Round-robin
//                grant between ports A and B, one registered RAM access per
//                cycle, read data routed back to the issuing port through a
//                tag pipeline of depth RD_LAT+1.
//                Optional macro RAM_ARB_FIXED_PRIO_EN: port A always wins
//                contention (port B may starve).
//                RD_LAT legal values: 1 (unregistered ram_q), 2 (registered).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ram_1port_arb #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  wire logic         sys_clk,
    input  wire logic         sys_rst,
    ram_1port_arb_if.slave    bus
);

    // Arbitration and selected-request wires
    logic              w_gnt_a;
    logic              w_gnt_b;
    logic              w_acc;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

    // Last granted port: 1 = B, 0 = A
    logic              r_last_b;

    // Registered RAM request
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_data;
    logic              r_ram_wren;
    logic              r_ram_rden;

    // Read tag pipeline: valid bit and issuing port (1 = B) per stage
    logic [RD_LAT:0]   r_tag_v;
    logic [RD_LAT:0]   r_tag_p;

    // Registered read responses
    logic              r_rvalid_a;
    logic              r_rvalid_b;
    logic [DATA_W-1:0] r_rdata_a;
    logic [DATA_W-1:0] r_rdata_b;

    // Grant decision: a lone requester wins outright; under contention the
    // winner depends on the configured policy.
    always_comb begin
`ifdef RAM_ARB_FIXED_PRIO_EN
        w_gnt_a = bus.req_a;
        w_gnt_b = bus.req_b & ~bus.req_a;
`else
        w_gnt_a = bus.req_a & (~bus.req_b | r_last_b);
        w_gnt_b = bus.req_b & ~w_gnt_a;
`endif
    end

    // Select the winning request's fields
    always_comb begin
        w_acc   = w_gnt_a | w_gnt_b;
        w_we    = w_gnt_b ? bus.we_b    : bus.we_a;
        w_addr  = w_gnt_b ? bus.addr_b  : bus.addr_a;
        w_wdata = w_gnt_b ? bus.wdata_b : bus.wdata_a;
    end

    // Remember who won the last accepted request; B after reset so A wins first
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_last_b <= 1'b1;
        end else if (w_acc) begin
            r_last_b <= w_gnt_b;
        end
    end

    // Launch one RAM access per accepted request; address/data hold when idle
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_ram_addr <= '0;
            r_ram_data <= '0;
            r_ram_wren <= 1'b0;
            r_ram_rden <= 1'b0;
        end else begin
            r_ram_wren <= w_acc & w_we;
            r_ram_rden <= w_acc & ~w_we;
            if (w_acc) begin
                r_ram_addr <= w_addr;
                r_ram_data <= w_wdata;
            end
        end
    end

    // Shift read tags in acceptance order so responses can never merge
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_tag_v <= '0;
            r_tag_p <= '0;
        end else begin
            r_tag_v <= {r_tag_v[RD_LAT-1:0], w_acc & ~w_we};
            r_tag_p <= {r_tag_p[RD_LAT-1:0], w_gnt_b};
        end
    end

    // Capture ram_q into the tagged port's response register
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_rvalid_a <= 1'b0;
            r_rvalid_b <= 1'b0;
            r_rdata_a  <= '0;
            r_rdata_b  <= '0;
        end else begin
            r_rvalid_a <= r_tag_v[RD_LAT] & ~r_tag_p[RD_LAT];
            r_rvalid_b <= r_tag_v[RD_LAT] &  r_tag_p[RD_LAT];
            if (r_tag_v[RD_LAT] & ~r_tag_p[RD_LAT]) begin
                r_rdata_a <= bus.ram_q;
            end
            if (r_tag_v[RD_LAT] & r_tag_p[RD_LAT]) begin
                r_rdata_b <= bus.ram_q;
            end
        end
    end

    assign bus.gnt_a    = w_gnt_a;
    assign bus.gnt_b    = w_gnt_b;
    assign bus.ram_addr = r_ram_addr;
    assign bus.ram_data = r_ram_data;
    assign bus.ram_wren = r_ram_wren;
    assign bus.ram_rden = r_ram_rden;
    assign bus.rvalid_a = r_rvalid_a;
    assign bus.rvalid_b = r_rvalid_b;
    assign bus.rdata_a  = r_rdata_a;
    assign bus.rdata_b  = r_rdata_b;

endmodule

`default_nettype wire

// File: tb/tb_ram_1port_arb.sv
// ============================================================================
//  Module      : tb_ram_1port_arb
//  Description : Self-checking bench for ram_1port_arb with a behavioural RAM
//                and a transaction-level reference model (grant rule, memory
//                image, ordered response queue).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ram_1port_arb;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 1;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 sys_clk = ~sys_clk;

    ram_1port_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_1port_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    // Behavioural single-port RAM, unregistered q (RD_LAT = 1)
    logic [7:0] ram_mem [32] = '{default: 8'h00};
    logic [4:0] ram_addr_q = '0;
    always @(posedge sys_clk) begin
        if (bus.ram_wren) ram_mem[bus.ram_addr] <= bus.ram_data;
        ram_addr_q <= bus.ram_addr;
    end
    assign bus.ram_q = ram_mem[ram_addr_q];

    // Reference model state
    typedef struct {
        bit         port;   // 1 = B
        logic [7:0] data;
        int         due;
    } resp_t;

    resp_t      rq[$];
    logic [7:0] ref_mem [32] = '{default: 8'h00};
    bit         exp_last_b = 1'b1;
    int         cyc = 0;
    bit         exp_gnt_a, exp_gnt_b, exp_rv_a, exp_rv_b;
    logic [7:0] exp_rd = '0;
    logic       exp_wren = 1'b0, exp_rden = 1'b0;
    logic [4:0] exp_addr = '0;
    logic [7:0] exp_data = '0;
    bit         obs_gnt_a, obs_gnt_b;
    int         checks = 0;
    int         failures = 0;

    task automatic drive_a(input logic r, input logic w, input logic [4:0] a, input logic [7:0] d);
        bus.req_a = r; bus.we_a = w; bus.addr_a = a; bus.wdata_a = d;
    endtask

    task automatic drive_b(input logic r, input logic w, input logic [4:0] a, input logic [7:0] d);
        bus.req_b = r; bus.we_b = w; bus.addr_b = a; bus.wdata_b = d;
    endtask

    task automatic model_reset();
        rq.delete();
        exp_last_b = 1'b1;
        exp_addr = '0; exp_data = '0; exp_wren = 1'b0; exp_rden = 1'b0;
        exp_rv_a = 1'b0; exp_rv_b = 1'b0;
    endtask

    // Advance one clock from a negedge: sample grants, apply the model's
    // acceptance rule, then land on the next negedge with expectations set.
    task automatic tick();
        resp_t      r;
        int         win;
        logic       we;
        logic [4:0] addr;
        logic [7:0] data;
        #1;
        obs_gnt_a = bus.gnt_a;
        obs_gnt_b = bus.gnt_b;
        win = 0;
`ifdef RAM_ARB_FIXED_PRIO_EN
        if (bus.req_a) win = 1;
        else if (bus.req_b) win = 2;
`else
        if (bus.req_a && bus.req_b) win = exp_last_b ? 1 : 2;
        else if (bus.req_a) win = 1;
        else if (bus.req_b) win = 2;
`endif
        exp_gnt_a = (win == 1);
        exp_gnt_b = (win == 2);
        exp_wren = 1'b0;
        exp_rden = 1'b0;
        if (win != 0) begin
            we   = (win == 1) ? bus.we_a    : bus.we_b;
            addr = (win == 1) ? bus.addr_a  : bus.addr_b;
            data = (win == 1) ? bus.wdata_a : bus.wdata_b;
            exp_addr = addr; exp_data = data;
            exp_wren = we;   exp_rden = !we;
            exp_last_b = (win == 2);
            if (we) begin
                ref_mem[addr] = data;
            end else begin
                r.port = (win == 2);
                r.data = ref_mem[addr];
                r.due  = cyc + 1 + RD_LAT + 1;
                rq.push_back(r);
            end
        end
        @(posedge sys_clk);
        cyc++;
        @(negedge sys_clk);
        exp_rv_a = 1'b0;
        exp_rv_b = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            r = rq.pop_front();
            if (r.port) exp_rv_b = 1'b1; else exp_rv_a = 1'b1;
            exp_rd = r.data;
        end
    endtask

    task automatic test_reset();
        drive_a(0, 0, 0, 0);
        drive_b(0, 0, 0, 0);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        @(negedge sys_clk);
        checks++;
        if ({bus.ram_wren, bus.ram_rden, bus.ram_addr, bus.ram_data, bus.rvalid_a,
             bus.rvalid_b, bus.rdata_a, bus.rdata_b} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: wren=%b rden=%b addr=%h data=%h rv=%b%b rd=%h/%h, required all zero",
                     bus.ram_wren, bus.ram_rden, bus.ram_addr, bus.ram_data, bus.rvalid_a,
                     bus.rvalid_b, bus.rdata_a, bus.rdata_b);
        end
        checks++;
        if (bus.gnt_a !== 1'b0 || bus.gnt_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_gnt: gnt=%b%b, required 00", bus.gnt_a, bus.gnt_b);
        end
        sys_rst = 1'b0;
        model_reset();
    endtask

    task automatic test_write_fill();
        int wr_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            drive_a(1, 1, 5'(i), 8'(i + 8'h10));
            tick();
            wr_cnt += int'(bus.ram_wren);
            checks++;
            if (obs_gnt_a !== exp_gnt_a || obs_gnt_b !== exp_gnt_b || obs_gnt_a !== 1'b1) begin
                failures++;
                $display("FAIL fill_gnt[%0d]: gnt=%b%b, required %b%b", i, obs_gnt_a, obs_gnt_b, exp_gnt_a, exp_gnt_b);
            end
            checks++;
            if (bus.ram_wren !== exp_wren || bus.ram_rden !== exp_rden ||
                bus.ram_addr !== exp_addr || bus.ram_data !== exp_data) begin
                failures++;
                $display("FAIL fill_ram[%0d]: wren=%b rden=%b addr=%h data=%h, required %b %b %h %h",
                         i, bus.ram_wren, bus.ram_rden, bus.ram_addr, bus.ram_data,
                         exp_wren, exp_rden, exp_addr, exp_data);
            end
            checks++;
            if (bus.rvalid_b !== 1'b0 || bus.rvalid_a !== 1'b0) begin
                failures++;
                $display("FAIL fill_rvalid[%0d]: rvalid=%b%b, required 00", i, bus.rvalid_a, bus.rvalid_b);
            end
        end
        drive_a(0, 0, 0, 0);
        tick();
        checks++;
        if (bus.ram_wren !== 1'b0 || bus.ram_addr !== 5'd31 || wr_cnt != 32) begin
            failures++;
            $display("FAIL fill_end: wren=%b addr=%h pulses=%0d, required 0 1f 32", bus.ram_wren, bus.ram_addr, wr_cnt);
        end
    endtask

    task automatic test_read_a5();
        int acc_cyc;
        int seen_cyc = -1;
        logic [7:0] seen_d = '0;
        drive_a(1, 0, 5, 0);
        tick();
        acc_cyc = cyc;
        drive_a(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.rvalid_a !== exp_rv_a || bus.rvalid_b !== exp_rv_b) begin
                failures++;
                $display("FAIL read5_rvalid[%0d]: rvalid=%b%b, required %b%b", i, bus.rvalid_a, bus.rvalid_b, exp_rv_a, exp_rv_b);
            end
            if (bus.rvalid_a === 1'b1) begin
                seen_cyc = cyc;
                seen_d = bus.rdata_a;
            end
        end
        checks++;
        if (seen_cyc - acc_cyc != 2 || seen_d !== 8'h15) begin
            failures++;
            $display("FAIL read5_latency: edges=%0d rdata=%h, required 2 15", seen_cyc - acc_cyc, seen_d);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seen_d = '0;
        drive_b(1, 1, 9, 8'hAA);
        tick();
        checks++;
        if (obs_gnt_b !== 1'b1 || bus.ram_wren !== 1'b1 || bus.ram_data !== 8'hAA) begin
            failures++;
            $display("FAIL b2b_write: gnt_b=%b wren=%b data=%h, required 1 1 aa", obs_gnt_b, bus.ram_wren, bus.ram_data);
        end
        drive_b(0, 0, 0, 0);
        drive_a(1, 0, 9, 0);
        tick();
        drive_a(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.rvalid_a !== exp_rv_a || (exp_rv_a && bus.rdata_a !== exp_rd)) begin
                failures++;
                $display("FAIL b2b_resp[%0d]: rvalid_a=%b rdata_a=%h, required %b %h", i, bus.rvalid_a, bus.rdata_a, exp_rv_a, exp_rd);
            end
            if (bus.rvalid_a === 1'b1) seen_d = bus.rdata_a;
        end
        checks++;
        if (seen_d !== 8'hAA) begin
            failures++;
            $display("FAIL b2b_data: rdata_a=%h, required aa", seen_d);
        end
    endtask

    task automatic test_reset_inflight();
        drive_a(1, 0, 1, 0);
        tick();
        drive_a(0, 0, 0, 0);
        drive_b(1, 0, 2, 0);
        tick();
        drive_b(0, 0, 0, 0);
        checks++;
        if (bus.ram_rden !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_rden: rden=%b, required 1", bus.ram_rden);
        end
        #2;
        sys_rst = 1'b1;
        #1;
        checks++;
        if (bus.ram_rden !== 1'b0 || bus.ram_wren !== 1'b0 || bus.ram_addr !== 5'd0) begin
            failures++;
            $display("FAIL rst_async: rden=%b wren=%b addr=%h, required 0 0 00", bus.ram_rden, bus.ram_wren, bus.ram_addr);
        end
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus.rvalid_a !== 1'b0 || bus.rvalid_b !== 1'b0 || exp_rv_a || exp_rv_b) begin
                failures++;
                $display("FAIL rst_no_rvalid[%0d]: rvalid=%b%b, required 00", i, bus.rvalid_a, bus.rvalid_b);
            end
        end
    endtask

`ifndef RAM_ARB_FIXED_PRIO_EN
    task automatic test_contention();
        drive_a(1, 0, 3, 0);
        drive_b(1, 0, 7, 0);
        for (int i = 0; i < 12; i++) begin
            if (i == 8) begin
                drive_a(0, 0, 0, 0);
                drive_b(0, 0, 0, 0);
            end
            tick();
            if (i < 8) begin
                checks++;
                if (obs_gnt_a !== exp_gnt_a || obs_gnt_b !== exp_gnt_b || obs_gnt_a !== (i % 2 == 0)) begin
                    failures++;
                    $display("FAIL rr_gnt[%0d]: gnt=%b%b, required %b%b", i, obs_gnt_a, obs_gnt_b, exp_gnt_a, exp_gnt_b);
                end
            end
            checks++;
            if (bus.rvalid_a !== exp_rv_a || bus.rvalid_b !== exp_rv_b ||
                (exp_rv_a && bus.rdata_a !== 8'h13) || (exp_rv_b && bus.rdata_b !== 8'h17)) begin
                failures++;
                $display("FAIL rr_resp[%0d]: rvalid=%b%b rdata=%h/%h, required %b%b 13/17",
                         i, bus.rvalid_a, bus.rvalid_b, bus.rdata_a, bus.rdata_b, exp_rv_a, exp_rv_b);
            end
        end
    endtask
`else
    task automatic test_fixed_prio();
        drive_a(1, 0, 3, 0);
        drive_b(1, 0, 7, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (obs_gnt_a !== 1'b1 || obs_gnt_b !== 1'b0) begin
                failures++;
                $display("FAIL fixed_gnt[%0d]: gnt=%b%b, required 10", i, obs_gnt_a, obs_gnt_b);
            end
        end
        drive_a(0, 0, 0, 0);
        tick();
        checks++;
        if (obs_gnt_b !== 1'b1 || obs_gnt_a !== 1'b0) begin
            failures++;
            $display("FAIL fixed_b_after: gnt=%b%b, required 01", obs_gnt_a, obs_gnt_b);
        end
        drive_b(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
    endtask
`endif

    task automatic test_random();
        bit pa = 0, pb = 0;
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            if (i < 390) begin
                if (!pa && ($urandom % 3 != 0)) begin
                    pa = 1;
                    drive_a(1, 1'($urandom % 2), 5'($urandom), 8'($urandom));
                end
                if (!pb && ($urandom % 3 != 0)) begin
                    pb = 1;
                    drive_b(1, 1'($urandom % 2), 5'($urandom), 8'($urandom));
                end
            end
            tick();
            if (exp_gnt_a) begin pa = 0; drive_a(0, 0, 0, 0); end
            if (exp_gnt_b) begin pb = 0; drive_b(0, 0, 0, 0); end
            checks++;
            if (obs_gnt_a !== exp_gnt_a || obs_gnt_b !== exp_gnt_b) begin
                failures++; bad++;
                if (bad < 10) $display("FAIL rand_gnt[%0d]: gnt=%b%b, required %b%b", i, obs_gnt_a, obs_gnt_b, exp_gnt_a, exp_gnt_b);
            end
            checks++;
            if (bus.ram_wren !== exp_wren || bus.ram_rden !== exp_rden ||
                bus.ram_addr !== exp_addr || bus.ram_data !== exp_data) begin
                failures++; bad++;
                if (bad < 10) $display("FAIL rand_ram[%0d]: wren=%b rden=%b addr=%h data=%h, required %b %b %h %h",
                                       i, bus.ram_wren, bus.ram_rden, bus.ram_addr, bus.ram_data,
                                       exp_wren, exp_rden, exp_addr, exp_data);
            end
            checks++;
            if (bus.rvalid_a !== exp_rv_a || bus.rvalid_b !== exp_rv_b ||
                (exp_rv_a && bus.rdata_a !== exp_rd) || (exp_rv_b && bus.rdata_b !== exp_rd)) begin
                failures++; bad++;
                if (bad < 10) $display("FAIL rand_resp[%0d]: rvalid=%b%b rdata=%h/%h, required %b%b %h",
                                       i, bus.rvalid_a, bus.rvalid_b, bus.rdata_a, bus.rdata_b,
                                       exp_rv_a, exp_rv_b, exp_rd);
            end
        end
        checks++;
        if (rq.size() != 0) begin
            failures++;
            $display("FAIL rand_drain: outstanding=%0d, required 0", rq.size());
        end
    endtask

    initial begin
        test_reset();
        test_write_fill();
        test_read_a5();
        test_back_to_back();
        test_reset_inflight();
`ifndef RAM_ARB_FIXED_PRIO_EN
        test_contention();
`else
        test_fixed_prio();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
